pipeline_sequencer: RTL and testbench
=====================================

# pipeline_sequencer

Central hazard and redirect controller for the 5-stage core. It consumes the branching unit's `branching_out_t` request bundle and the data-memory busy flag, and drives the PC-write and redirect controls plus per-stage pipeline-register enable/flush strobes. A small FSM masks stale hold requests after a redirect and freezes the pipe during memory waits. Saturating flush and stall counters provide performance visibility. It sits between `branching` and the IF/DEC/EXE pipeline registers.

## Interface
- `CNT_W`, default 16, width of the performance counters.
- `Clock`  in  1  core clock, rising edge.
- `nReset`  in  1  reset; asynchronous and active-low.
- `br`  in  `branching_out_t`  request from the branching unit: `flush`, `hold`, `branch`, `bypass`, `PCnext[31:0]`, `PCcurrent[31:0]`.
- `memBusy`  in  1  data memory cannot complete the access in MEM this cycle.
- `pcWrite`  out  1  PC register load enable.
- `pcRedirect`  out  1  PC loads `pcTarget` instead of PC+4.
- `pcTarget`  out  32  redirect address.
- `ifdecEn`, `decexeEn`, `exememEn`  out  1 each  pipeline-register enables.
- `ifdecFlush`, `decexeFlush`  out  1 each  load a bubble (NOP, valid=0) into that register.
- `flushCount`  out  `CNT_W`  EXE-stage flushes taken, saturating.
- `stallCycles`  out  `CNT_W`  cycles with `pcWrite`=0, saturating.

## Operation
- State encoding: RUN, REDIRECT, MEM_WAIT. Reset state is RUN.
- Default outputs: `pcWrite`=1, `pcRedirect`=0, `pcTarget`=0, all enables 1, all flushes 0.
- Target arithmetic:
  - `br.bypass`=1: `pcTarget` = `br.PCnext` (absolute, JALR).
  - Otherwise: `pcTarget` = `br.PCcurrent` + `br.PCnext`, modulo 2^32.
- Request priority, highest first: `memBusy` > `br.flush` > (`br.hold` & `br.branch`) > `br.hold` > none.
- `memBusy`=1 (any state):
  - All enables 0, `pcWrite`=0, no flushes, no redirect.
  - Next state MEM_WAIT.
- `br.flush`=1 (EXE misprediction or JALR resolution):
  - `pcWrite`=1, `pcRedirect`=1.
  - `ifdecFlush`=1, `decexeFlush`=1.
  - `flushCount` +1. Next state REDIRECT.
- `br.hold`=1 and `br.branch`=1 (decode-stage JAL or predicted-taken branch):
  - `pcWrite`=1, `pcRedirect`=1, `ifdecFlush`=1 to kill the sequential fetch.
  - State unchanged (RUN).
- `br.hold`=1 and `br.branch`=0 (load-use or JALR wait):
  - `pcWrite`=0, `ifdecEn`=0, `decexeFlush`=1 to insert a bubble.
- REDIRECT:
  - DEC holds a bubble, so `br.hold` is ignored for exactly one cycle.
  - `br.flush` and `memBusy` are still honoured per priority.
  - Next state RUN unless `memBusy` or `br.flush` is asserted.
- MEM_WAIT:
  - With `memBusy`=0, behaves exactly as RUN in the same cycle (requests evaluated, no dead cycle).
  - Next state follows the RUN rules.
- Counters:
  - Both counters saturate at all-ones and do not wrap.
  - `stallCycles` increments in every cycle where `pcWrite`=0.

## Timing
- All control outputs are combinational from the current state plus inputs (Mealy), valid in the same cycle as the request.
- State and counters update on the rising `Clock` edge.
- Counter outputs are registered and reflect events from previous cycles (1-cycle latency).
- Reset values:
  - State RUN; `flushCount`=0, `stallCycles`=0.
  - Combinational outputs take their default values while inputs are idle.
- `nReset` asserted mid-operation:
  - Immediately (asynchronously) forces state to RUN and both counters to 0.
  - No pending redirect is retained.
- Simultaneous `br.flush` and `memBusy`: freeze wins. The flush is taken in the first cycle `memBusy`=0, because upstream holds `br` stable while the pipe is frozen.
- Simultaneous `br.flush` and `br.hold`: flush wins, and `ifdecEn` stays 1.
- `br.bypass` without `br.flush` or `br.hold` is ignored.

## Test plan
- Reset, then idle inputs for 5 cycles -> `pcWrite`=1, `pcRedirect`=0, all enables 1, `flushCount`=0, `stallCycles`=0.
- `br.hold`=1, `br.branch`=1, `PCcurrent`=0x100, `PCnext`=0x20 -> `pcTarget`=0x120, `pcRedirect`=1, `ifdecFlush`=1, state stays RUN.
- `br.flush`=1, `branch`=1, `PCcurrent`=0x200, `PCnext`=4 -> `pcTarget`=0x204, both flushes 1. Next cycle state REDIRECT: `br.hold`=1 gives `pcWrite`=1, `ifdecEn`=1. `flushCount`=1.
- `br.flush`=1, `bypass`=1, `PCnext`=0x3000, `PCcurrent`=0x500 -> `pcTarget`=0x3000. Separately, `PCcurrent`=0xFFFF_FFFC, `PCnext`=8 -> `pcTarget`=0x4.
- `memBusy`=1 for 3 cycles with `br.flush` asserted from cycle 2 -> all enables 0 for 3 cycles, `stallCycles`=3, redirect issued in cycle 4 only.
- Hold `br.hold`=1, `branch`=0 for 70000 cycles -> `stallCycles` saturates at 0xFFFF. Assert `nReset` low mid-run -> counters 0 immediately.

Source files
------------

// File: rtl/pipeline_sequencer.sv
// Hazard and redirect controller for the 5-stage core: turns branching-unit requests and the
// data-memory busy flag into PC controls, per-stage enable/flush strobes and perf counters.

package pipeline_sequencer_pkg;

  typedef struct packed {
    logic        flush;
    logic        hold;
    logic        branch;
    logic        bypass;
    logic [31:0] PCnext;
    logic [31:0] PCcurrent;
  } branching_out_t;

endpackage

module pipeline_sequencer
  import pipeline_sequencer_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic                 Clock,
  input  logic                 nReset,
  input  branching_out_t       br,
  input  logic                 memBusy,
  output logic                 pcWrite,
  output logic                 pcRedirect,
  output logic [31:0]          pcTarget,
  output logic                 ifdecEn,
  output logic                 decexeEn,
  output logic                 exememEn,
  output logic                 ifdecFlush,
  output logic                 decexeFlush,
  output logic [CNT_W-1:0]     flushCount,
  output logic [CNT_W-1:0]     stallCycles
);

  typedef enum logic [1:0] {
    StRun,
    StRedirect,
    StMemWait
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [31:0]       redirect_target;
  logic              hold_ok;
  logic              flush_taken;

  // JALR supplies an absolute address; everything else is PC-relative.
  assign redirect_target = br.bypass ? br.PCnext : (br.PCcurrent + br.PCnext);

  // DEC holds a bubble right after an EXE redirect, so its hold request is stale.
  assign hold_ok = br.hold && (state_q != StRedirect);

  always_comb begin
    pcWrite     = 1'b1;
    pcRedirect  = 1'b0;
    pcTarget    = '0;
    ifdecEn     = 1'b1;
    decexeEn    = 1'b1;
    exememEn    = 1'b1;
    ifdecFlush  = 1'b0;
    decexeFlush = 1'b0;
    flush_taken = 1'b0;
    state_d     = StRun;

    if (memBusy) begin
      pcWrite  = 1'b0;
      ifdecEn  = 1'b0;
      decexeEn = 1'b0;
      exememEn = 1'b0;
      state_d  = StMemWait;
    end else if (br.flush) begin
      pcRedirect  = 1'b1;
      pcTarget    = redirect_target;
      ifdecFlush  = 1'b1;
      decexeFlush = 1'b1;
      flush_taken = 1'b1;
      state_d     = StRedirect;
    end else if (hold_ok && br.branch) begin
      pcRedirect = 1'b1;
      pcTarget   = redirect_target;
      ifdecFlush = 1'b1;
    end else if (hold_ok) begin
      pcWrite     = 1'b0;
      ifdecEn     = 1'b0;
      decexeFlush = 1'b1;
    end
  end

  always_comb begin
    flush_cnt_d = flush_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (flush_taken && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + 1'b1;
    end
    if (!pcWrite && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state_q     <= StRun;
      flush_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign flushCount  = flush_cnt_q;
  assign stallCycles = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Bench for pipeline_sequencer: directed vector table, multi-cycle corner sequences and
// randomized traffic against a request-priority reference model.

module tb_pipeline_sequencer;
  import pipeline_sequencer_pkg::*;

  localparam int unsigned CntMax = 65535;

  logic           Clock = 1'b0;
  logic           nReset;
  branching_out_t br;
  logic           memBusy;
  logic           pcWrite, pcRedirect;
  logic [31:0]    pcTarget;
  logic           ifdecEn, decexeEn, exememEn, ifdecFlush, decexeFlush;
  logic [15:0]    flushCount, stallCycles;

  int checks   = 0;
  int failures = 0;

  // Reference model state: was a flush taken last cycle, plus plain integer counters.
  bit m_masked;
  int m_flush;
  int m_stall;

  pipeline_sequencer #(
    .CNT_W(16)
  ) dut (
    .Clock       (Clock),
    .nReset      (nReset),
    .br          (br),
    .memBusy     (memBusy),
    .pcWrite     (pcWrite),
    .pcRedirect  (pcRedirect),
    .pcTarget    (pcTarget),
    .ifdecEn     (ifdecEn),
    .decexeEn    (decexeEn),
    .exememEn    (exememEn),
    .ifdecFlush  (ifdecFlush),
    .decexeFlush (decexeFlush),
    .flushCount  (flushCount),
    .stallCycles (stallCycles)
  );

  always #5 Clock = ~Clock;

  // Control vector order: {pcWrite, pcRedirect, ifdecEn, decexeEn, exememEn, ifdecFlush, decexeFlush}
  localparam logic [6:0] CtlIdle  = 7'b1011100;
  localparam logic [6:0] CtlFrz   = 7'b0000000;
  localparam logic [6:0] CtlFlush = 7'b1111111;
  localparam logic [6:0] CtlJump  = 7'b1111110;
  localparam logic [6:0] CtlStall = 7'b0001101;

  typedef struct {
    logic        mb, fl, ho, brn, byp;
    logic [31:0] nxt, cur;
    logic [6:0]  exp_ctl;
    logic [31:0] exp_tgt;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v > CntMax) ? CntMax : v;
  endfunction

  task automatic model(input logic mb, fl, ho, brn, byp, input logic [31:0] nxt, cur,
                       input bit masked, output logic [6:0] ctl, output logic [31:0] tgt,
                       output bit took_flush, output bit stalled);
    logic [31:0] dest;
    dest       = byp ? nxt : 32'(cur + nxt);
    tgt        = 32'h0;
    took_flush = 1'b0;
    if (mb) begin
      ctl = CtlFrz;
    end else if (fl) begin
      ctl        = CtlFlush;
      tgt        = dest;
      took_flush = 1'b1;
    end else if (ho && !masked && brn) begin
      ctl = CtlJump;
      tgt = dest;
    end else if (ho && !masked) begin
      ctl = CtlStall;
    end else begin
      ctl = CtlIdle;
    end
    stalled = !ctl[6];
  endtask

  // Called just after a rising edge; checks at the falling edge, then advances one cycle.
  task automatic step(input logic mb, fl, ho, brn, byp, input logic [31:0] nxt, cur,
                      output logic [6:0] act_ctl, output logic [31:0] act_tgt);
    logic [6:0]  ec;
    logic [31:0] et;
    bit          tf, st;
    memBusy      = mb;
    br.flush     = fl;
    br.hold      = ho;
    br.branch    = brn;
    br.bypass    = byp;
    br.PCnext    = nxt;
    br.PCcurrent = cur;
    @(negedge Clock);
    model(mb, fl, ho, brn, byp, nxt, cur, m_masked, ec, et, tf, st);
    act_ctl = {pcWrite, pcRedirect, ifdecEn, decexeEn, exememEn, ifdecFlush, decexeFlush};
    act_tgt = pcTarget;
    chk("ctl", {25'h0, act_ctl}, {25'h0, ec});
    chk("target", act_tgt, et);
    chk("flush_count", {16'h0, flushCount}, m_flush);
    chk("stall_cycles", {16'h0, stallCycles}, m_stall);
    @(posedge Clock);
    if (tf) m_flush = sat(m_flush + 1);
    if (st) m_stall = sat(m_stall + 1);
    m_masked = tf;
    #1;
  endtask

  task automatic idle();
    logic [6:0]  c;
    logic [31:0] t;
    step(0, 0, 0, 0, 0, 32'h0, 32'h0, c, t);
  endtask

  initial begin
    vec_t        vecs[10];
    logic [6:0]  c;
    logic [31:0] t;
    int          n_redir, n_frozen;

    vecs[0] = '{0, 0, 0, 0, 0, 32'h0,    32'h0,        CtlIdle,  32'h0};
    vecs[1] = '{0, 0, 1, 1, 0, 32'h20,   32'h100,      CtlJump,  32'h120};
    vecs[2] = '{0, 1, 0, 1, 0, 32'h4,    32'h200,      CtlFlush, 32'h204};
    vecs[3] = '{0, 1, 0, 0, 1, 32'h3000, 32'h500,      CtlFlush, 32'h3000};
    vecs[4] = '{0, 1, 0, 0, 0, 32'h8,    32'hFFFF_FFFC, CtlFlush, 32'h4};
    vecs[5] = '{0, 0, 1, 0, 0, 32'h44,   32'h80,       CtlStall, 32'h0};
    vecs[6] = '{1, 1, 0, 0, 0, 32'h10,   32'h10,       CtlFrz,   32'h0};
    vecs[7] = '{0, 1, 1, 0, 0, 32'h10,   32'h10,       CtlFlush, 32'h20};
    vecs[8] = '{0, 0, 0, 0, 1, 32'h1234, 32'h0,        CtlIdle,  32'h0};
    vecs[9] = '{0, 0, 1, 1, 1, 32'h8000, 32'h40,       CtlJump,  32'h8000};

    nReset   = 1'b0;
    memBusy  = 1'b0;
    br       = '0;
    m_masked = 1'b0;
    m_flush  = 0;
    m_stall  = 0;
    repeat (2) @(posedge Clock);
    #1 nReset = 1'b1;

    repeat (5) idle();

    for (int i = 0; i < 10; i++) begin
      step(vecs[i].mb, vecs[i].fl, vecs[i].ho, vecs[i].brn, vecs[i].byp,
           vecs[i].nxt, vecs[i].cur, c, t);
      chk($sformatf("vec%0d_ctl", i), {25'h0, c}, {25'h0, vecs[i].exp_ctl});
      chk($sformatf("vec%0d_target", i), t, vecs[i].exp_tgt);
      idle();
    end

    // Stale hold right after an EXE flush is ignored for exactly one cycle.
    step(0, 1, 0, 1, 0, 32'h4, 32'h200, c, t);
    step(0, 0, 1, 0, 0, 32'h0, 32'h0, c, t);
    chk("redirect_masks_hold", {25'h0, c}, {25'h0, CtlIdle});
    step(0, 0, 1, 0, 0, 32'h0, 32'h0, c, t);
    chk("hold_after_mask", {25'h0, c}, {25'h0, CtlStall});
    idle();

    // Memory wait with a flush arriving mid-freeze: redirect only once the pipe unfreezes.
    n_redir  = 0;
    n_frozen = 0;
    for (int i = 0; i < 4; i++) begin
      step(i < 3, i >= 1, 0, 1, 0, 32'h10, 32'h40, c, t);
      if (c[5]) n_redir++;
      if (c[4:2] == 3'b000) n_frozen++;
      if (i == 3) chk("memwait_redirect_target", t, 32'h50);
    end
    chk("memwait_redirects", n_redir, 1);
    chk("memwait_frozen_cycles", n_frozen, 3);
    idle();

    for (int i = 0; i < 400; i++) begin
      step($urandom_range(5) == 0, $urandom_range(4) == 0, $urandom_range(2) == 0,
           $urandom_range(1) == 1, $urandom_range(3) == 0, $urandom, $urandom, c, t);
    end
    idle();

    // Long load-use stall drives the stall counter into saturation.
    memBusy   = 1'b0;
    br        = '0;
    br.hold   = 1'b1;
    repeat (70000) @(posedge Clock);
    m_stall = sat(m_stall + 70000);
    #1;
    chk("stall_saturated", {16'h0, stallCycles}, m_stall);
    chk("stall_all_ones", {16'h0, stallCycles}, 32'hFFFF);
    @(negedge Clock);
    #2 nReset = 1'b0;
    #1;
    chk("async_reset_stall", {16'h0, stallCycles}, 32'h0);
    chk("async_reset_flush", {16'h0, flushCount}, 32'h0);
    br = '0;
    @(posedge Clock);
    #1 nReset = 1'b1;
    m_masked = 1'b0;
    m_flush  = 0;
    m_stall  = 0;
    repeat (3) idle();
    step(0, 1, 0, 0, 0, 32'h4, 32'h0, c, t);
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
